seq_divider_8bit: RTL and testbench

SEQ_DIVIDER_8BIT -- requirements
Module: seq_divider_8bit

---
 rtl/seq_divider_8bit.sv | 165 ++++++++++++++++
 tb/tb_seq_divider_8bit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider_8bit.sv
// seq_divider_8bit
//   Sequential unsigned restoring divider. One quotient bit per clock,
//   MSB first, so a division occupies WIDTH cycles in RUN. A zero divisor
//   is resolved immediately from IDLE, with no RUN phase.
//
// Ports
//   clk          : single clock, rising edge active
//   reset        : synchronous, active-high reset
//   start        : request a new division (ignored while busy)
//   dividend     : unsigned numerator, sampled when start is accepted
//   divisor      : unsigned denominator, sampled when start is accepted
//   quotient     : registered quotient, updated only on completion
//   remainder    : registered remainder, updated only on completion
//   busy         : high while a division is iterating
//   done         : one-cycle pulse, new results are valid
//   div_by_zero  : last completed request had divisor 0
module seq_divider_8bit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Shared add/sub form: a + (sub ? ~b : b) + sub.
  function automatic logic [WIDTH:0] add_sub(input logic [WIDTH:0] a,
                                             input logic [WIDTH:0] b,
                                             input logic           sub);
    add_sub = a + (sub ? ~b : b) + {{WIDTH{1'b0}}, sub};
  endfunction

  state_t           state_r, state_n;
  // Stored partial remainder. Its extra top bit is always 0 after a
  // restore step, so only WIDTH bits are kept between iterations.
  logic [WIDTH-1:0] p_r, p_n;
  // Dividend bits shift out of the top while quotient bits shift in below.
  logic [WIDTH-1:0] work_r, work_n;
  logic [WIDTH-1:0] dvs_r, dvs_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [WIDTH-1:0] quotient_r, quotient_n;
  logic [WIDTH-1:0] remainder_r, remainder_n;
  logic             busy_r, busy_n;
  logic             done_r, done_n;
  logic             dbz_r, dbz_n;

  logic [WIDTH:0]   shifted_s;
  logic [WIDTH:0]   trial_s;
  logic             q_bit_s;
  logic [WIDTH-1:0] p_next_s;
  logic [WIDTH-1:0] work_next_s;

  // One restoring-division step on the current working registers.
  always_comb begin
    shifted_s   = {p_r, work_r[WIDTH-1]};
    trial_s     = add_sub(shifted_s, {1'b0, dvs_r}, 1'b1);
    // A clear MSB means the subtraction did not borrow.
    q_bit_s     = ~trial_s[WIDTH];
    if (q_bit_s) begin
      p_next_s = trial_s[WIDTH-1:0];
    end else begin
      p_next_s = shifted_s[WIDTH-1:0];
    end
    work_next_s = {work_r[WIDTH-2:0], q_bit_s};
  end

  // Next-state and next-output logic of the IDLE/RUN controller.
  always_comb begin
    state_n     = state_r;
    p_n         = p_r;
    work_n      = work_r;
    dvs_n       = dvs_r;
    cnt_n       = cnt_r;
    quotient_n  = quotient_r;
    remainder_n = remainder_r;
    done_n      = 1'b0;
    dbz_n       = dbz_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          if (divisor != {WIDTH{1'b0}}) begin
            state_n = RUN;
            p_n     = {WIDTH{1'b0}};
            work_n  = dividend;
            dvs_n   = divisor;
            cnt_n   = {CNT_W{1'b0}};
          end else begin
            // Divide by zero completes at once without entering RUN.
            done_n      = 1'b1;
            dbz_n       = 1'b1;
            quotient_n  = {WIDTH{1'b1}};
            remainder_n = dividend;
          end
        end else begin
          state_n = IDLE;
        end
      end
      RUN: begin
        p_n    = p_next_s;
        work_n = work_next_s;
        if (cnt_r == CNT_W'(WIDTH - 1)) begin
          state_n     = IDLE;
          cnt_n       = {CNT_W{1'b0}};
          quotient_n  = work_next_s;
          remainder_n = p_next_s;
          done_n      = 1'b1;
          dbz_n       = 1'b0;
        end else begin
          cnt_n = cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n == RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      p_r         <= {WIDTH{1'b0}};
      work_r      <= {WIDTH{1'b0}};
      dvs_r       <= {WIDTH{1'b0}};
      cnt_r       <= {CNT_W{1'b0}};
      quotient_r  <= {WIDTH{1'b0}};
      remainder_r <= {WIDTH{1'b0}};
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      dbz_r       <= 1'b0;
    end else begin
      state_r     <= state_n;
      p_r         <= p_n;
      work_r      <= work_n;
      dvs_r       <= dvs_n;
      cnt_r       <= cnt_n;
      quotient_r  <= quotient_n;
      remainder_r <= remainder_n;
      busy_r      <= busy_n;
      done_r      <= done_n;
      dbz_r       <= dbz_n;
    end
  end

  assign quotient    = quotient_r;
  assign remainder   = remainder_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_seq_divider_8bit.sv
// tb_seq_divider_8bit
//   Scoreboard bench for seq_divider_8bit. Each accepted request pushes its
//   expected result (plain / and % arithmetic) and the cycle its done pulse
//   should appear; a negedge monitor pops and compares on every done.
module tb_seq_divider_8bit;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         div_by_zero;

  seq_divider_8bit #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    int a;
    int b;
    int q;
    int r;
    int z;
    int cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic [W-1:0] hold_q = '0;
  logic [W-1:0] hold_r = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model: plain integer division; divide by zero gives all ones.
  function automatic exp_t model(input int a, input int b);
    exp_t e;
    e.a = a;
    e.b = b;
    if (b == 0) begin
      e.q = (1 << W) - 1;
      e.r = a;
      e.z = 1;
    end else begin
      e.q = a / b;
      e.r = a % b;
      e.z = 0;
    end
    e.cyc = 0;
    return e;
  endfunction

  // Called at posedge+1; start is sampled at the next edge.
  task automatic issue(input int a, input int b, input bit push);
    exp_t e;
    dividend = a[W-1:0];
    divisor  = b[W-1:0];
    start    = 1'b1;
    if (push) begin
      e     = model(a, b);
      e.cyc = cyc + 1 + ((b == 0) ? 0 : W);
      sb.push_back(e);
    end
    @(posedge clk); #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
  endtask

  // Waits for done, scrambling operands meanwhile; counts busy cycles.
  task automatic wait_done(input int max, output int bc);
    bc = 0;
    for (int i = 0; i < max; i++) begin
      if (done === 1'b1) return;
      if (busy === 1'b1) bc++;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk); #1;
    end
    chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: compare every done against the scoreboard; results hold while busy.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      hold_q = '0;
      hold_r = '0;
    end else if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("quotient", quotient, mon_e.q);
        chk("remainder", remainder, mon_e.r);
        chk("div_by_zero", div_by_zero, mon_e.z);
        chk("done_cycle", cyc, mon_e.cyc);
        chk("busy_at_done", busy, 0);
        if (mon_e.z == 0) begin
          chk("identity", quotient * mon_e.b + remainder, mon_e.a);
          chk("rem_lt_div", (remainder < mon_e.b) ? 1 : 0, 1);
        end
      end
      hold_q = quotient;
      hold_r = remainder;
    end else if (busy === 1'b1) begin
      chk("quotient_hold", quotient, hold_q);
      chk("remainder_hold", remainder, hold_r);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int bc;
  int ta[4] = '{255, 5, 255, 0};
  int tb[4] = '{1, 9, 255, 3};

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    step(2);
    chk("reset_quotient", quotient, 0);
    chk("reset_remainder", remainder, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    reset = 1'b0;
    step(1);

    // Basic division.
    issue(100, 7, 1'b1);
    wait_done(20, bc);
    chk("busy_cycles_100_7", bc, 8);
    chk("q_100_7", quotient, 14);
    chk("r_100_7", remainder, 2);
    step(1);
    chk("done_one_cycle", done, 0);

    // Boundary operands.
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], tb[i], 1'b1);
      wait_done(20, bc);
      step(1);
    end

    // Divide by zero.
    issue(200, 0, 1'b1);
    wait_done(5, bc);
    chk("dbz_busy_cycles", bc, 0);
    step(1);
    chk("dbz_done_cleared", done, 0);
    chk("dbz_holds", div_by_zero, 1);
    chk("dbz_q_holds", quotient, 255);

    // Start while busy is ignored.
    issue(100, 7, 1'b1);
    step(2);
    dividend = 8'd50;
    divisor  = 8'd5;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    wait_done(20, bc);
    chk("busy_start_q", quotient, 14);
    chk("busy_start_r", remainder, 2);
    step(12);

    // Reset mid-operation, with a start that coincides with reset.
    issue(100, 7, 1'b0);
    step(3);
    reset    = 1'b1;
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd2;
    step(1);
    reset = 1'b0;
    start = 1'b0;
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_dbz", div_by_zero, 0);
    step(12);
    chk("abort_idle_busy", busy, 0);
    issue(9, 2, 1'b1);
    wait_done(20, bc);
    step(1);

    // Back-to-back: second start in the done cycle.
    issue(100, 7, 1'b1);
    wait_done(20, bc);
    issue(77, 8, 1'b1);
    wait_done(20, bc);
    chk("b2b_q", quotient, 9);
    chk("b2b_r", remainder, 5);

    // Random back-to-back sweep with occasional zero divisors.
    repeat (300) begin
      int a;
      int b;
      a = $urandom_range(0, 255);
      b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(0, 255);
      issue(a, b, 1'b1);
      wait_done(20, bc);
    end

    step(12);
    chk("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
